pipeline_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 8-bit 4-stage processor (IF, ID, EX, WB). It decodes the instruction held in the IF/ID register and drives the write-enables and flush controls of the PC, the IF/ID register and the ID/EX register. It handles three cases: load-use stalls through a single-entry load scoreboard, jump redirects with wrong-path flush, and HALT with pipeline drain and resume. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/load_scoreboard.sv | 37 +++
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the 4-stage pipeline sequencing controller:
// instruction field positions, opcodes, NOP encoding and FSM states.
package pipe_pkg;

  // Instruction field positions within the 8-bit instruction word
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int RD_MSB = 5;
  localparam int RD_LSB = 3;
  localparam int RS_MSB = 2;
  localparam int RS_LSB = 0;

  // Opcodes
  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_JUMP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  // All-zero word is a NOP: it reads nothing and never hazards
  localparam logic [7:0] NOP = 8'h00;

  // Controller states
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/load_scoreboard.sv
// Single-entry load scoreboard: remembers the destination of the most
// recent LOAD and how many more cycles that register stays busy.
module load_scoreboard #(
  parameter int LOAD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue,
  input  logic [2:0] rd,
  input  logic [2:0] q_a,
  input  logic [2:0] q_b,
  output logic       a_busy,
  output logic       b_busy,
  output logic       cnt_zero
);

  logic [2:0] busy_rd;
  logic [1:0] busy_cnt;

  // Load a new entry on issue, otherwise count the busy window down to zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_rd  <= '0;
      busy_cnt <= '0;
    end else if (issue) begin
      busy_rd  <= rd;
      busy_cnt <= 2'(LOAD_LAT);
    end else if (busy_cnt != 2'd0) begin
      busy_cnt <= busy_cnt - 2'd1;
    end
  end

  assign cnt_zero = (busy_cnt == 2'd0);
  assign a_busy   = !cnt_zero && (q_a == busy_rd);
  assign b_busy   = !cnt_zero && (q_b == busy_rd);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, jump redirect/flush,
// HALT drain and resume, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int LOAD_LAT     = 1,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instr_id,
  input  logic       resume,
  output logic       pc_write_en,
  output logic       pc_sel_jump,
  output logic [7:0] jump_target,
  output logic       ifid_write_en,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       halted,
  output logic [7:0] stall_count
);

  logic [1:0] op;
  logic [2:0] rd;
  logic [2:0] rs;
  logic       is_nop;

  assign op     = instr_id[OP_MSB:OP_LSB];
  assign rd     = instr_id[RD_MSB:RD_LSB];
  assign rs     = instr_id[RS_MSB:RS_LSB];
  assign is_nop = (instr_id == NOP);

  logic   rd_busy;
  logic   rs_busy;
  logic   cnt_zero;
  logic   hazard;
  logic   issue;
  logic   stall_inc;
  state_t state;
  state_t state_next;
  logic [7:0] drain_cnt;
  logic [7:0] drain_next;
  logic [7:0] stall_cnt;

  load_scoreboard #(
    .LOAD_LAT(LOAD_LAT)
  ) u_sb (
    .clk     (clk),
    .reset   (reset),
    .issue   (issue),
    .rd      (rd),
    .q_a     (rd),
    .q_b     (rs),
    .a_busy  (rd_busy),
    .b_busy  (rs_busy),
    .cnt_zero(cnt_zero)
  );

  // Hazard detect; a busy scoreboard blocks any new LOAD (single entry)
  always_comb begin
    hazard = 1'b0;
    if (state == RUN) begin
      case (op)
        OP_ALU:  hazard = !is_nop && (rd_busy || rs_busy);
        OP_LOAD: hazard = rd_busy || rs_busy || !cnt_zero;
        default: hazard = 1'b0;
      endcase
    end
  end

  // Next-state and control output decode
  always_comb begin
    state_next    = state;
    drain_next    = drain_cnt;
    pc_write_en   = 1'b0;
    pc_sel_jump   = 1'b0;
    ifid_write_en = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    halted        = 1'b0;
    issue         = 1'b0;
    stall_inc     = 1'b0;
    case (state)
      RUN: begin
        if (hazard) begin
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
        end else if (op == OP_JUMP) begin
          pc_write_en = 1'b1;
          pc_sel_jump = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (op == OP_HALT) begin
          idex_bubble = 1'b1;
          drain_next  = 8'(DRAIN_CYCLES);
          state_next  = DRAIN;
        end else begin
          pc_write_en   = 1'b1;
          ifid_write_en = 1'b1;
          issue         = (op == OP_LOAD);
        end
      end
      DRAIN: begin
        idex_bubble = 1'b1;
        drain_next  = (drain_cnt != 8'd0) ? drain_cnt - 8'd1 : 8'd0;
        // Leave once this cycle's decrement reaches zero and no load is outstanding
        if (drain_cnt <= 8'd1 && cnt_zero) begin
          state_next = HALTED;
        end
      end
      HALTED: begin
        halted      = 1'b1;
        idex_bubble = 1'b1;
        if (resume) begin
          pc_write_en   = 1'b1;
          ifid_write_en = 1'b1;
          state_next    = RUN;
        end
      end
      default: begin
        idex_bubble = 1'b1;
        state_next  = RUN;
      end
    endcase
    // While reset is held the pipeline is frozen with a bubble into EX
    if (!reset) begin
      pc_write_en   = 1'b0;
      pc_sel_jump   = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b0;
      idex_bubble   = 1'b1;
      halted        = 1'b0;
      issue         = 1'b0;
      stall_inc     = 1'b0;
    end
  end

  // FSM state and drain counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
    end
  end

  // Saturating count of load-use stall cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall_inc && stall_cnt != 8'hFF) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

  assign stall_count = stall_cnt;
  assign jump_target = {2'b00, instr_id[5:0]};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two instances (LOAD_LAT=1 and 3)
// share stimulus; a cycle-numbered reference model predicts each cycle's controls.
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN = 2;

  typedef struct packed {
    logic       pcw;
    logic       sel;
    logic [7:0] jt;
    logic       ifw;
    logic       fl;
    logic       bub;
    logic       halt;
    logic [7:0] stall;
  } exp_t;

  typedef struct {
    exp_t v;
    int   cyc;
    logic [7:0] ins;
  } item_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] instr_id = 8'h00;
  logic       resume = 1'b0;

  logic       pcw0, sel0, ifw0, fl0, bub0, halt0;
  logic [7:0] jt0, st0;
  logic       pcw1, sel1, ifw1, fl1, bub1, halt1;
  logic [7:0] jt1, st1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_LAT(1), .DRAIN_CYCLES(DRAIN)) u_lat1 (
    .clk(clk), .reset(reset), .instr_id(instr_id), .resume(resume),
    .pc_write_en(pcw0), .pc_sel_jump(sel0), .jump_target(jt0),
    .ifid_write_en(ifw0), .ifid_flush(fl0), .idex_bubble(bub0),
    .halted(halt0), .stall_count(st0)
  );

  pipeline_hazard_ctrl #(.LOAD_LAT(3), .DRAIN_CYCLES(DRAIN)) u_lat3 (
    .clk(clk), .reset(reset), .instr_id(instr_id), .resume(resume),
    .pc_write_en(pcw1), .pc_sel_jump(sel1), .jump_target(jt1),
    .ifid_write_en(ifw1), .ifid_flush(fl1), .idex_bubble(bub1),
    .halted(halt1), .stall_count(st1)
  );

  // Reference model: busy window tracked as absolute cycle numbers,
  // HALT completion computed as a cycle number at HALT time.
  int m_mode[2];        // 0 running, 1 draining, 2 halted
  bit m_valid[2];
  int m_breg[2];
  int m_last[2];        // last cycle in which the loaded register is busy
  int m_halt_at[2];     // first halted cycle
  int m_stall[2];
  int m_cyc = 0;

  item_t q0[$];
  item_t q1[$];

  task automatic model_step(input int k, input bit rst, input logic [7:0] ins,
                            input bit res, output exp_t e);
    int lat, op, rd, rs, rem, wait_c;
    bit busy_any, hz;
    lat = (k == 0) ? 1 : 3;
    e = '0;
    e.bub = 1'b1;
    if (!rst) begin
      m_mode[k]  = 0;
      m_valid[k] = 1'b0;
      m_stall[k] = 0;
      return;
    end
    e.stall  = 8'(m_stall[k]);
    op       = int'(ins[7:6]);
    rd       = int'(ins[5:3]);
    rs       = int'(ins[2:0]);
    busy_any = m_valid[k] && (m_cyc <= m_last[k]);
    rem      = busy_any ? (m_last[k] - m_cyc + 1) : 0;
    if (m_mode[k] == 1 && m_cyc >= m_halt_at[k]) m_mode[k] = 2;
    if (m_mode[k] == 0) begin
      hz = 1'b0;
      if (op == 0 && ins != 8'h00 && busy_any && (rd == m_breg[k] || rs == m_breg[k])) hz = 1'b1;
      if (op == 1 && busy_any) hz = 1'b1;
      if (hz) begin
        m_stall[k] = (m_stall[k] < 255) ? m_stall[k] + 1 : 255;
      end else if (op == 2) begin
        e.pcw = 1'b1;
        e.sel = 1'b1;
        e.jt  = {2'b00, ins[5:0]};
        e.fl  = 1'b1;
      end else if (op == 3) begin
        wait_c = DRAIN;
        if (rem > wait_c) wait_c = rem;
        if (wait_c < 1) wait_c = 1;
        m_halt_at[k] = m_cyc + wait_c + 1;
        m_mode[k]    = 1;
      end else begin
        e.pcw = 1'b1;
        e.ifw = 1'b1;
        e.bub = 1'b0;
        if (op == 1) begin
          m_valid[k] = 1'b1;
          m_breg[k]  = rd;
          m_last[k]  = m_cyc + lat;
        end
      end
    end else if (m_mode[k] == 2) begin
      e.halt = 1'b1;
      if (res) begin
        e.pcw     = 1'b1;
        e.ifw     = 1'b1;
        m_mode[k] = 0;
      end
    end
  endtask

  // Drive one cycle of stimulus and queue the predicted response of both instances
  task automatic step(input bit rst, input logic [7:0] ins, input bit res);
    item_t it;
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    instr_id = ins;
    resume   = res;
    it.cyc = m_cyc;
    it.ins = ins;
    model_step(0, rst, ins, res, e);
    it.v = e;
    q0.push_back(it);
    model_step(1, rst, ins, res, e);
    it.v = e;
    q1.push_back(it);
    m_cyc++;
  endtask

  function automatic string fmt(exp_t v);
    return $sformatf("pcw=%b sel=%b jt=%h ifw=%b fl=%b bub=%b halt=%b stall=%0d",
                     v.pcw, v.sel, v.jt, v.ifw, v.fl, v.bub, v.halt, v.stall);
  endfunction

  function automatic void check(input string name, input item_t it, input exp_t act_in);
    exp_t act;
    act = act_in;
    if (!it.v.sel) act.jt = 8'h00;
    checks++;
    if (act !== it.v) begin
      errors++;
      $display("FAIL %s cycle %0d ins=%h got {%s} expected {%s}",
               name, it.cyc, it.ins, fmt(act), fmt(it.v));
    end
  endfunction

  // Monitor: compare the presented controls against the queued predictions
  always @(negedge clk) begin
    item_t a, b;
    if (q0.size() > 0 && q1.size() > 0) begin
      a = q0.pop_front();
      b = q1.pop_front();
      check("lat1", a, {pcw0, sel0, jt0, ifw0, fl0, bub0, halt0, st0});
      check("lat3", b, {pcw1, sel1, jt1, ifw1, fl1, bub1, halt1, st1});
      $display("cycle %0d rst=%b ins=%h res=%b | lat1 %s | lat3 %s",
               a.cyc, reset, a.ins, resume, fmt(a.v), fmt(b.v));
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    // Reset
    for (int i = 0; i < 3; i++) step(1'b0, 8'h19, 1'b0);
    // Load-use: LOAD r1,[r2] then dependent ALU r3,r1
    step(1'b1, 8'h4A, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h19, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    // Independent ALU after LOAD, then a structurally stalled LOAD
    step(1'b1, 8'h4A, 1'b0);
    step(1'b1, 8'h1A, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h4B, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b0);
    // Jump
    step(1'b1, 8'h95, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    // HALT, stay frozen, then resume
    for (int i = 0; i < 7; i++) step(1'b1, 8'hC0, 1'b0);
    step(1'b1, 8'hC0, 1'b1);
    step(1'b1, 8'h01, 1'b1);
    step(1'b1, 8'h00, 1'b0);
    // Saturation: a repeating LOAD keeps colliding with its own scoreboard entry
    for (int i = 0; i < 600; i++) step(1'b1, 8'h4A, 1'b0);
    // Reset during DRAIN with a load still outstanding
    step(1'b1, 8'h4A, 1'b0);
    step(1'b1, 8'hC0, 1'b0);
    step(1'b1, 8'hC0, 1'b0);
    step(1'b0, 8'hC0, 1'b0);
    step(1'b0, 8'h19, 1'b0);
    step(1'b1, 8'h19, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] ins;
      ins = 8'($urandom);
      r = int'($urandom_range(0, 15));
      if (r == 0) ins = 8'h00;
      else if (r == 1) ins[7:6] = 2'b11;
      else if (ins[7:6] == 2'b11) ins[7:6] = 2'($urandom_range(0, 2));
      step(($urandom_range(0, 199) != 0), ins, ($urandom_range(0, 3) == 0));
    end
    step(1'b1, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
